// File: rtl/mapper_mem_arbiter.sv
// Arbitrates the shared ROM/RAM port between mapper CPU accesses and the ROM loader.
// Optional watchdog (MAPPER_ARB_WATCHDOG_EN) aborts accesses the memory never acknowledges.
module mapper_mem_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int CPU_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              wd_err
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_LOAD} state_e;

  localparam logic [3:0] BURST4 = 4'(CPU_BURST);

  if (CPU_BURST < 1 || CPU_BURST > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("mapper_mem_arbiter: CPU_BURST or TIMEOUT out of range");
  end

  state_e            state_q, state_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_wr_q, cpu_wr_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_din_q, cpu_din_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic              ld_ready_q, ld_ready_d;

  logic cpu_take, pend_eff, busy, done, grant_cpu, grant_ld, timeout;

  // A fresh cpu_req competes in the same cycle so mem_req can rise on the next one.
  always_comb begin
    cpu_take  = cpu_req & ~cpu_pend_q & (state_q != S_CPU);
    pend_eff  = cpu_pend_q | cpu_take;
    busy      = (state_q != S_IDLE);
    done      = busy & (mem_ack | timeout);
    grant_ld  = (state_q == S_IDLE) & ld_valid & (~pend_eff | (streak_q == BURST4));
    grant_cpu = (state_q == S_IDLE) & pend_eff & ~grant_ld;
  end

  always_comb begin
    state_d    = state_q;
    cpu_pend_d = cpu_pend_q;
    cpu_wr_d   = cpu_wr_q;
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    streak_d   = streak_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    cpu_dout_d = cpu_dout_q;
    ld_ready_d = 1'b0;

    if (cpu_take) begin
      cpu_pend_d = 1'b1;
      cpu_wr_d   = cpu_wr;
      cpu_addr_d = cpu_addr;
      cpu_din_d  = cpu_din;
    end

    if (grant_cpu) begin
      state_d    = S_CPU;
      mem_req_d  = 1'b1;
      mem_we_d   = cpu_take ? cpu_wr   : cpu_wr_q;
      mem_addr_d = cpu_take ? cpu_addr : cpu_addr_q;
      mem_din_d  = cpu_take ? cpu_din  : cpu_din_q;
    end else if (grant_ld) begin
      state_d    = S_LOAD;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = ld_addr;
      mem_din_d  = ld_data;
    end

    // A watchdog abort completes like an ack, but reads return 8'hFF.
    if (done) begin
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
      if (state_q == S_CPU) begin
        cpu_pend_d = 1'b0;
        if (!cpu_wr_q) cpu_dout_d = mem_ack ? mem_dout : 8'hFF;
      end else begin
        ld_ready_d = 1'b1;
      end
    end

    if (!ld_valid || grant_ld)              streak_d = 4'd0;
    else if (grant_cpu && streak_q != BURST4) streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cpu_pend_q <= 1'b0;
      cpu_wr_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      streak_q   <= 4'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_dout_q <= 8'hFF;
      ld_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_pend_q <= cpu_pend_d;
      cpu_wr_q   <= cpu_wr_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      streak_q   <= streak_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_dout_q <= cpu_dout_d;
      ld_ready_q <= ld_ready_d;
    end
  end

`ifdef MAPPER_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q;
  logic       wd_err_q;

  // Fires in the TIMEOUT-th cycle of an unacknowledged request.
  assign timeout = busy & ~mem_ack & (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= 8'd0;
      wd_err_q <= 1'b0;
    end else begin
      if (grant_cpu || grant_ld)  wd_cnt_q <= 8'd0;
      else if (busy && !mem_ack)  wd_cnt_q <= wd_cnt_q + 8'd1;
      if (timeout)                wd_err_q <= 1'b1;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign timeout = 1'b0;
  assign wd_err  = 1'b0;
`endif

  assign cpu_wait = cpu_req | cpu_pend_q;
  assign cpu_dout = cpu_dout_q;
  assign ld_ready = ld_ready_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule
